// File: rtl/hjoin2_rr_arbiter_pkg.sv
// Shared widths, debounce depth, FSM encodings and grant helper for the two-input merger.
package hjoin2_rr_arbiter_pkg;

  localparam int unsigned NS_ADDRESS_SIZE = 8;
  localparam int unsigned NS_DATA_SIZE    = 8;
  localparam int unsigned NS_REDUN_SIZE   = 4;
  localparam int unsigned NS_REQ_CKS      = 2;

  localparam logic [1:0] HJ_IDLE    = 2'd0;
  localparam logic [1:0] HJ_SEND    = 2'd1;
  localparam logic [1:0] HJ_RELEASE = 2'd2;
  localparam logic [1:0] HJ_ACK_IN  = 2'd3;

  // A lone requester always wins; a tie goes to the one not served last time.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction

endpackage

// File: rtl/hreq_debouncer.sv
// Level filter: the output follows the raw input only after it has held a new level
// for CKS consecutive clocks.
module hreq_debouncer #(
  parameter int unsigned CKS = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic ckd
);

  localparam int unsigned CW = (CKS > 1) ? $clog2(CKS) : 1;
  localparam logic [CW-1:0] CntMax = CW'(CKS - 1);

  logic          ckd_q, ckd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    ckd_d = ckd_q;
    cnt_d = cnt_q;
    if (raw == ckd_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      ckd_d = raw;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ckd_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ckd_q <= ckd_d;
      cnt_q <= cnt_d;
    end
  end

  assign ckd = ckd_q;

endmodule

// File: rtl/hjoin2_rr_arbiter.sv
// Two-input round-robin merger for 4-phase req/ack channels; forwards the granted
// message on snd0 and flags requesters that withdraw before being acknowledged.
module hjoin2_rr_arbiter
  import hjoin2_rr_arbiter_pkg::*;
#(
  parameter int unsigned MY_LOCAL_ADDR = 0,
  parameter int unsigned ASZ           = NS_ADDRESS_SIZE,
  parameter int unsigned DSZ           = NS_DATA_SIZE,
  parameter int unsigned RSZ           = NS_REDUN_SIZE,
  parameter int unsigned RCV_REQ_CKS   = NS_REQ_CKS
) (
  input  logic           gch_clk,
  input  logic           gch_reset_n,
  output logic           gch_ready,
  input  logic           rcv0_req,
  output logic           rcv0_ack_out,
  input  logic [ASZ-1:0] rcv0_src,
  input  logic [ASZ-1:0] rcv0_dst,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic [RSZ-1:0] rcv0_red,
  input  logic           rcv1_req,
  output logic           rcv1_ack_out,
  input  logic [ASZ-1:0] rcv1_src,
  input  logic [ASZ-1:0] rcv1_dst,
  input  logic [DSZ-1:0] rcv1_dat,
  input  logic [RSZ-1:0] rcv1_red,
  output logic           snd0_req_out,
  input  logic           snd0_ack,
  output logic [ASZ-1:0] snd0_src_out,
  output logic [ASZ-1:0] snd0_dst_out,
  output logic [DSZ-1:0] snd0_dat_out,
  output logic [RSZ-1:0] snd0_red_out,
  output logic           err0_error,
  output logic           err0_inp,
  output logic [ASZ-1:0] err0_adr
);

  logic [1:0] ckd_req;
  logic       ckd_ack;

  hreq_debouncer #(.CKS(RCV_REQ_CKS)) u_db_req0 (
    .clk     (gch_clk),
    .reset_n (gch_reset_n),
    .raw     (rcv0_req),
    .ckd     (ckd_req[0])
  );

  hreq_debouncer #(.CKS(RCV_REQ_CKS)) u_db_req1 (
    .clk     (gch_clk),
    .reset_n (gch_reset_n),
    .raw     (rcv1_req),
    .ckd     (ckd_req[1])
  );

  hreq_debouncer #(.CKS(RCV_REQ_CKS)) u_db_ack (
    .clk     (gch_clk),
    .reset_n (gch_reset_n),
    .raw     (snd0_ack),
    .ckd     (ckd_ack)
  );

  logic [1:0]     state_q, state_d;
  logic           rg_rdy_q;
  logic           rg_last_q, rg_last_d;
  logic           grant_q, grant_d;
  logic           snd_req_q, snd_req_d;
  logic [1:0]     ack_q, ack_d;
  logic [ASZ-1:0] src_q, src_d, dst_q, dst_d;
  logic [DSZ-1:0] dat_q, dat_d;
  logic [RSZ-1:0] red_q, red_d;
  logic           err_q, err_d;
  logic           inp_q, inp_d;
  logic           gnt_new;
  logic           req_g;

  assign gnt_new = rr_pick(ckd_req, rg_last_q);
  assign req_g   = ckd_req[grant_q];

  always_comb begin
    state_d   = state_q;
    rg_last_d = rg_last_q;
    grant_d   = grant_q;
    snd_req_d = snd_req_q;
    ack_d     = ack_q;
    src_d     = src_q;
    dst_d     = dst_q;
    dat_d     = dat_q;
    red_d     = red_q;
    err_d     = err_q;
    inp_d     = inp_q;

    case (state_q)
      HJ_IDLE: begin
        if (rg_rdy_q && (ckd_req != 2'b00)) begin
          grant_d   = gnt_new;
          rg_last_d = gnt_new;
          src_d     = gnt_new ? rcv1_src : rcv0_src;
          dst_d     = gnt_new ? rcv1_dst : rcv0_dst;
          dat_d     = gnt_new ? rcv1_dat : rcv0_dat;
          red_d     = gnt_new ? rcv1_red : rcv0_red;
          snd_req_d = 1'b1;
          state_d   = HJ_SEND;
        end
      end
      HJ_SEND: begin
        if (ckd_ack) begin
          snd_req_d = 1'b0;
          state_d   = HJ_RELEASE;
        end
      end
      HJ_RELEASE: begin
        if (!ckd_ack) begin
          ack_d[grant_q] = 1'b1;
          state_d        = HJ_ACK_IN;
        end
      end
      HJ_ACK_IN: begin
        // An early drop by the requester lands here as an ordinary release.
        if (!req_g) begin
          ack_d   = 2'b00;
          state_d = HJ_IDLE;
        end
      end
      default: state_d = HJ_IDLE;
    endcase

    if (!req_g && (state_q == HJ_SEND || state_q == HJ_RELEASE)) begin
      err_d = 1'b1;
      if (!err_q) inp_d = grant_q;
    end
  end

  always_ff @(posedge gch_clk or negedge gch_reset_n) begin
    if (!gch_reset_n) begin
      state_q   <= HJ_IDLE;
      rg_rdy_q  <= 1'b0;
      rg_last_q <= 1'b1;
      grant_q   <= 1'b0;
      snd_req_q <= 1'b0;
      ack_q     <= 2'b00;
      src_q     <= '0;
      dst_q     <= '0;
      dat_q     <= '0;
      red_q     <= '0;
      err_q     <= 1'b0;
      inp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rg_rdy_q  <= 1'b1;
      rg_last_q <= rg_last_d;
      grant_q   <= grant_d;
      snd_req_q <= snd_req_d;
      ack_q     <= ack_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      dat_q     <= dat_d;
      red_q     <= red_d;
      err_q     <= err_d;
      inp_q     <= inp_d;
    end
  end

  assign gch_ready    = rg_rdy_q;
  assign rcv0_ack_out = ack_q[0];
  assign rcv1_ack_out = ack_q[1];
  assign snd0_req_out = snd_req_q;
  assign snd0_src_out = src_q;
  assign snd0_dst_out = dst_q;
  assign snd0_dat_out = dat_q;
  assign snd0_red_out = red_q;
  assign err0_error   = err_q;
  assign err0_inp     = inp_q;
  assign err0_adr     = ASZ'(MY_LOCAL_ADDR);

endmodule
